pipeline_four_array_top: RTL and testbench
==========================================

# pipeline_four_array_top

Four-stage chained elementwise MAC engine built from four 4x4 PE arrays. It is used for tiled matrix-vector products: array s receives the k-slice that is s steps older, and each stage adds its products onto the previous stage's registered partial sums, so `result_out_3` carries a full 16-wide k-chunk sum per cycle. It sits between the tile scheduler (which staggers k-bases by 12 per array per step) and the row accumulator.

## Interface

Parameters:
- `TILE_SIZE`, default 4: array dimension (rows = cols).
- `DATA_WIDTH`, default 16: signed operand width (Q8.8 when `FRAC_BITS`=8).
- `ACC_WIDTH`, default 32: signed result width.
- `FRAC_BITS`, default 8: fraction bits, used by mode 01.

Ports:
- `clk`  in  1  single clock; all logic on rising edge.
- `rst`  in  1  reset; **synchronous, active-high** (already decided).
- `mode`  in  2  00 = chained MAC, 01 = elementwise fixed-point multiply, 10 = elementwise add, 11 = same as 00.
- `valid_in`  in  1  all eight input tiles valid this cycle.
- `A0_mat`..`A3_mat`  in  [TILE_SIZE][TILE_SIZE]×DATA_WIDTH signed  operand A for arrays 0..3.
- `B0_mat`..`B3_mat`  in  same shape  operand B for arrays 0..3.
- `valid_out`  out  1  `result_out_*` updated by the previous valid step.
- `done_tile`  out  1  one-cycle pulse at the end of a valid burst.
- `result_out_0`..`result_out_3`  out  [TILE_SIZE][TILE_SIZE]×ACC_WIDTH signed  stage registers R0..R3.

## Operation

- P_s[i][j] = A_s[i][j] × B_s[i][j], full signed product, sign-extended or truncated to ACC_WIDTH.
- Mode 00/11, on an edge with `valid_in`=1:
  - R0 ← P_0 <<< log2(TILE_SIZE).
  - R_s ← R_(s-1) + (P_s <<< log2(TILE_SIZE)) for s = 1..3, using the pre-edge R_(s-1).
  - The ×TILE_SIZE scale is part of the MAC contract.
- Mode 01: R_s ← P_s >>> FRAC_BITS (arithmetic). No chaining.
- Mode 10: R_s ← sext(A_s) + sext(B_s). No chaining.
- Arithmetic is two's complement and wraps modulo 2^ACC_WIDTH. There is no saturation.
- When `valid_in`=0, R0..R3 hold their values.
- There is no clear between bursts. Scheduler zero-padding flushes stale partials: a zero tile contributes 0.
- `mode` is sampled on every valid edge. A mode change mid-burst applies per cycle.

## Timing

- Reset (edge with `rst`=1): R0..R3 = 0, `valid_out` = 0, `done_tile` = 0. Reset overrides `valid_in`.
- Per-stage latency is one cycle: data presented at edge n is visible in `result_out_s` after edge n.
- A k-chunk whose array-0 slice enters at step m reaches `result_out_3` after step m+3.
- `valid_out` ← `valid_in` (registered, 1 cycle). There is no backpressure and no stall.
- `done_tile` ← `valid_out` & ~`valid_in`: it goes high for exactly one cycle, the cycle after the last `valid_out`=1.
- Back-to-back bursts with a single idle cycle between them must each produce one `done_tile` pulse.
- Reset asserted mid-burst: all outputs are 0 on the next cycle, and no `done_tile` pulse is generated.

## Structure

- Shared package:
  - `mode_e` enum: MAC=2'b00, MUL=2'b01, ADD=2'b10.
  - Tile typedefs for the data tile and the accumulator tile.
- One sub-module, `pe_array_stage`. It is instantiated 4×, with `chain_in` tied to 0 for stage 0.
  - Inputs: the A/B tiles, `chain_in` tile, `mode`, `valid_in`.
  - Output: the registered R tile.
- The top level holds the `valid_out`/`done_tile` logic.

## Test plan

- Reset: hold `rst`=1 for 3 cycles with random inputs and `valid_in`=1 → all results 0, `valid_out`=0, `done_tile`=0.
- Single MAC chain:
  - Stimulus, steps 0..3: A0=256,B0=128 at step 0; A1=2,B1=3 at step 1; A2=-1,B2=5 at step 2; A3=4,B3=4 at step 3. Every element, all other tiles zero.
  - Required: `result_out_3` = 4×(32768+6−5+16) = 131140 in every element after step 3.
- 40×256 matvec schedule:
  - Stimulus: 19 steps per 4-row block, with kb_s = k_base − 12s and k_base = 0,16,…,288; zero-pad out-of-range slices.
  - Required: the sum over valid cycles of row sums of `result_out_3` equals 4·Σ A[r][k]·B[k], exactly, for all 40 rows.
- Mode 01:
  - A=0x0200 (2.0), B=0xFF00 (−1.0) → R = −512 (−2.0 in Q8.8).
  - A=−1, B=1 → R = −1, which checks the arithmetic shift.
- Mode 10: A=32767, B=32767 → 65534. There is no 16-bit wrap.
- Handshake:
  - Stimulus: `valid_in` high 5 cycles, low 1 cycle, high 2 cycles.
  - Required: `valid_out` is the 1-cycle delayed copy, `done_tile` pulses twice, and R holds during the idle cycle.

Source files
------------

// File: rtl/pipeline_four_array_top_pkg.sv
// Shared types for the chained four-stage PE-array MAC engine.
// Default tile geometry, the operating-mode encoding and whole-tile typedefs.
package pipeline_four_array_top_pkg;

  localparam int PKG_TILE_SIZE  = 4;
  localparam int PKG_DATA_WIDTH = 16;
  localparam int PKG_ACC_WIDTH  = 32;
  localparam int PKG_FRAC_BITS  = 8;
  localparam int PKG_NUM_STAGES = 4;

  typedef enum logic [1:0] {
    MAC = 2'b00,
    MUL = 2'b01,
    ADD = 2'b10
  } mode_e;

  typedef logic [PKG_TILE_SIZE-1:0][PKG_TILE_SIZE-1:0][PKG_DATA_WIDTH-1:0] data_tile_t;
  typedef logic [PKG_TILE_SIZE-1:0][PKG_TILE_SIZE-1:0][PKG_ACC_WIDTH-1:0]  acc_tile_t;

endpackage

// File: rtl/pipeline_four_array_top_pe_array_stage.sv
// One elementwise PE array stage: per-element multiply/add with an optional
// incoming partial-sum tile, captured into the stage register on valid cycles.
module pe_array_stage
  import pipeline_four_array_top_pkg::*;
#(
  parameter int TILE_SIZE  = PKG_TILE_SIZE,
  parameter int DATA_WIDTH = PKG_DATA_WIDTH,
  parameter int ACC_WIDTH  = PKG_ACC_WIDTH,
  parameter int FRAC_BITS  = PKG_FRAC_BITS
) (
  input  logic                                                  clk,
  input  logic                                                  rst,
  input  logic [1:0]                                            mode,
  input  logic                                                  valid_in,
  input  logic [TILE_SIZE-1:0][TILE_SIZE-1:0][DATA_WIDTH-1:0]   a_tile,
  input  logic [TILE_SIZE-1:0][TILE_SIZE-1:0][DATA_WIDTH-1:0]   b_tile,
  input  logic [TILE_SIZE-1:0][TILE_SIZE-1:0][ACC_WIDTH-1:0]    chain_in,
  output logic [TILE_SIZE-1:0][TILE_SIZE-1:0][ACC_WIDTH-1:0]    r_tile
);

  localparam int PROD_WIDTH  = 2 * DATA_WIDTH;
  localparam int EXT_WIDTH   = (PROD_WIDTH > ACC_WIDTH) ? PROD_WIDTH : ACC_WIDTH;
  localparam int SCALE_SHIFT = $clog2(TILE_SIZE);

  logic [TILE_SIZE-1:0][TILE_SIZE-1:0][ACC_WIDTH-1:0] w_next_tile;
  logic [TILE_SIZE-1:0][TILE_SIZE-1:0][ACC_WIDTH-1:0] r_acc;
  mode_e                                               w_mode;

  assign w_mode = mode_e'(mode);

  genvar gi, gj;
  generate
    for (gi = 0; gi < TILE_SIZE; gi++) begin : g_row
      for (gj = 0; gj < TILE_SIZE; gj++) begin : g_col
        logic signed [DATA_WIDTH-1:0] w_a;
        logic signed [DATA_WIDTH-1:0] w_b;
        logic signed [PROD_WIDTH-1:0] w_full;
        logic signed [EXT_WIDTH-1:0]  w_ext;
        logic signed [ACC_WIDTH-1:0]  w_p;
        logic signed [ACC_WIDTH-1:0]  w_chain;
        logic signed [ACC_WIDTH-1:0]  w_next;

        assign w_a     = a_tile[gi][gj];
        assign w_b     = b_tile[gi][gj];
        assign w_chain = chain_in[gi][gj];
        assign w_full  = PROD_WIDTH'(w_a) * PROD_WIDTH'(w_b);
        // Sign-extend the full product first so a narrow ACC_WIDTH truncates cleanly.
        assign w_ext   = EXT_WIDTH'(w_full);
        assign w_p     = w_ext[ACC_WIDTH-1:0];

        always_comb begin
          w_next = w_chain + (w_p <<< SCALE_SHIFT);
          case (w_mode)
            MUL:     w_next = w_p >>> FRAC_BITS;
            ADD:     w_next = ACC_WIDTH'(w_a) + ACC_WIDTH'(w_b);
            default: ;
          endcase
        end

        assign w_next_tile[gi][gj] = w_next;
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc <= '0;
    end else if (valid_in) begin
      r_acc <= w_next_tile;
    end
  end

  assign r_tile = r_acc;

endmodule

// File: rtl/pipeline_four_array_top.sv
// Four chained PE-array stages forming a 16-wide k-chunk MAC pipeline, plus the
// valid/done handshake that frames each burst for the downstream row accumulator.
module pipeline_four_array_top
  import pipeline_four_array_top_pkg::*;
#(
  parameter int TILE_SIZE  = PKG_TILE_SIZE,
  parameter int DATA_WIDTH = PKG_DATA_WIDTH,
  parameter int ACC_WIDTH  = PKG_ACC_WIDTH,
  parameter int FRAC_BITS  = PKG_FRAC_BITS
) (
  input  logic                                                clk,
  input  logic                                                rst,
  input  logic [1:0]                                          mode,
  input  logic                                                valid_in,
  input  logic [TILE_SIZE-1:0][TILE_SIZE-1:0][DATA_WIDTH-1:0] A0_mat,
  input  logic [TILE_SIZE-1:0][TILE_SIZE-1:0][DATA_WIDTH-1:0] A1_mat,
  input  logic [TILE_SIZE-1:0][TILE_SIZE-1:0][DATA_WIDTH-1:0] A2_mat,
  input  logic [TILE_SIZE-1:0][TILE_SIZE-1:0][DATA_WIDTH-1:0] A3_mat,
  input  logic [TILE_SIZE-1:0][TILE_SIZE-1:0][DATA_WIDTH-1:0] B0_mat,
  input  logic [TILE_SIZE-1:0][TILE_SIZE-1:0][DATA_WIDTH-1:0] B1_mat,
  input  logic [TILE_SIZE-1:0][TILE_SIZE-1:0][DATA_WIDTH-1:0] B2_mat,
  input  logic [TILE_SIZE-1:0][TILE_SIZE-1:0][DATA_WIDTH-1:0] B3_mat,
  output logic                                                valid_out,
  output logic                                                done_tile,
  output logic [TILE_SIZE-1:0][TILE_SIZE-1:0][ACC_WIDTH-1:0]  result_out_0,
  output logic [TILE_SIZE-1:0][TILE_SIZE-1:0][ACC_WIDTH-1:0]  result_out_1,
  output logic [TILE_SIZE-1:0][TILE_SIZE-1:0][ACC_WIDTH-1:0]  result_out_2,
  output logic [TILE_SIZE-1:0][TILE_SIZE-1:0][ACC_WIDTH-1:0]  result_out_3
);

  logic [TILE_SIZE-1:0][TILE_SIZE-1:0][DATA_WIDTH-1:0] w_a     [PKG_NUM_STAGES];
  logic [TILE_SIZE-1:0][TILE_SIZE-1:0][DATA_WIDTH-1:0] w_b     [PKG_NUM_STAGES];
  logic [TILE_SIZE-1:0][TILE_SIZE-1:0][ACC_WIDTH-1:0]  w_chain [PKG_NUM_STAGES];
  logic [TILE_SIZE-1:0][TILE_SIZE-1:0][ACC_WIDTH-1:0]  w_r     [PKG_NUM_STAGES];
  logic                                                r_valid_out;
  logic                                                r_done_tile;

  assign w_a[0] = A0_mat;
  assign w_a[1] = A1_mat;
  assign w_a[2] = A2_mat;
  assign w_a[3] = A3_mat;
  assign w_b[0] = B0_mat;
  assign w_b[1] = B1_mat;
  assign w_b[2] = B2_mat;
  assign w_b[3] = B3_mat;

  genvar gi;
  generate
    for (gi = 0; gi < PKG_NUM_STAGES; gi++) begin : g_stage
      // Each stage builds on the previous stage's registered partials; stage 0 starts fresh.
      if (gi == 0) begin : g_head
        assign w_chain[gi] = '0;
      end else begin : g_link
        assign w_chain[gi] = w_r[gi-1];
      end

      pe_array_stage #(
        .TILE_SIZE  (TILE_SIZE),
        .DATA_WIDTH (DATA_WIDTH),
        .ACC_WIDTH  (ACC_WIDTH),
        .FRAC_BITS  (FRAC_BITS)
      ) u_stage (
        .clk      (clk),
        .rst      (rst),
        .mode     (mode),
        .valid_in (valid_in),
        .a_tile   (w_a[gi]),
        .b_tile   (w_b[gi]),
        .chain_in (w_chain[gi]),
        .r_tile   (w_r[gi])
      );
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid_out <= 1'b0;
      r_done_tile <= 1'b0;
    end else begin
      r_valid_out <= valid_in;
      r_done_tile <= r_valid_out & ~valid_in;
    end
  end

  assign valid_out    = r_valid_out;
  assign done_tile    = r_done_tile;
  assign result_out_0 = w_r[0];
  assign result_out_1 = w_r[1];
  assign result_out_2 = w_r[2];
  assign result_out_3 = w_r[3];

endmodule

// File: tb/tb_pipeline_four_array_top.sv
// Self-checking bench for pipeline_four_array_top: directed scenarios from the
// datasheet plus randomized traffic against an arithmetic reference model.
module tb_pipeline_four_array_top;
  import pipeline_four_array_top_pkg::*;

  logic       clk;
  logic       rst;
  logic [1:0] mode;
  logic       valid_in;
  data_tile_t a_t [4];
  data_tile_t b_t [4];
  logic       valid_out;
  logic       done_tile;
  acc_tile_t  res0, res1, res2, res3;

  int n_vec = 0;
  int n_err = 0;

  // Reference state: stage registers and handshake flags.
  int m_r [4][4][4];
  bit m_vo;
  bit m_done;

  pipeline_four_array_top #(
    .TILE_SIZE(4), .DATA_WIDTH(16), .ACC_WIDTH(32), .FRAC_BITS(8)
  ) dut (
    .clk(clk), .rst(rst), .mode(mode), .valid_in(valid_in),
    .A0_mat(a_t[0]), .A1_mat(a_t[1]), .A2_mat(a_t[2]), .A3_mat(a_t[3]),
    .B0_mat(b_t[0]), .B1_mat(b_t[1]), .B2_mat(b_t[2]), .B3_mat(b_t[3]),
    .valid_out(valid_out), .done_tile(done_tile),
    .result_out_0(res0), .result_out_1(res1), .result_out_2(res2), .result_out_3(res3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] res(int s, int i, int j);
    case (s)
      0:       return res0[i][j];
      1:       return res1[i][j];
      2:       return res2[i][j];
      default: return res3[i][j];
    endcase
  endfunction

  // Arithmetic model of one clock edge, computed straight from the stage equations.
  function automatic void model_step();
    int nr [4][4][4];
    int a, b, p;
    nr = m_r;
    if (rst) begin
      foreach (nr[s, i, j]) nr[s][i][j] = 0;
      m_r = nr; m_vo = 0; m_done = 0;
      return;
    end
    if (valid_in) begin
      foreach (nr[s, i, j]) begin
        a = int'($signed(a_t[s][i][j]));
        b = int'($signed(b_t[s][i][j]));
        p = a * b;
        if (mode == 2'b01)      nr[s][i][j] = p >>> 8;
        else if (mode == 2'b10) nr[s][i][j] = a + b;
        else                    nr[s][i][j] = ((s == 0) ? 0 : m_r[s-1][i][j]) + p * 4;
      end
    end
    m_done = m_vo && !valid_in;
    m_vo   = valid_in;
    m_r    = nr;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    model_step();
  endtask

  task automatic clear_tiles();
    for (int s = 0; s < 4; s++) begin
      a_t[s] = '0;
      b_t[s] = '0;
    end
  endtask

  task automatic fill_tile(int s, int av, int bv);
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        a_t[s][i][j] = 16'(av);
        b_t[s][i][j] = 16'(bv);
      end
  endtask

  task automatic randomize_tiles(int lo, int hi);
    for (int s = 0; s < 4; s++)
      for (int i = 0; i < 4; i++)
        for (int j = 0; j < 4; j++) begin
          a_t[s][i][j] = 16'($urandom_range(hi - lo) + lo);
          b_t[s][i][j] = 16'($urandom_range(hi - lo) + lo);
        end
  endtask

  task automatic test_reset();
    rst = 1'b1; valid_in = 1'b1; mode = 2'($urandom_range(3));
    for (int c = 0; c < 3; c++) begin
      randomize_tiles(-30000, 30000);
      tick();
      for (int s = 0; s < 4; s++)
        for (int i = 0; i < 4; i++)
          for (int j = 0; j < 4; j++) begin
            n_vec++;
            if (res(s, i, j) !== 32'd0) begin
              n_err++;
              $display("FAIL reset_r%0d[%0d][%0d]: got %0d want 0", s, i, j, $signed(res(s, i, j)));
            end
          end
      n_vec++;
      if (valid_out !== 1'b0 || done_tile !== 1'b0) begin
        n_err++;
        $display("FAIL reset_flags: got vo=%b done=%b want 0 0", valid_out, done_tile);
      end
    end
    rst = 1'b0; valid_in = 1'b0;
    tick();
  endtask

  task automatic test_mac_chain();
    mode = 2'b00; valid_in = 1'b1;
    clear_tiles(); fill_tile(0, 256, 128); tick();
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        n_vec++;
        if (res(0, i, j) !== 32'd131072) begin
          n_err++;
          $display("FAIL chain_r0[%0d][%0d]: got %0d want 131072", i, j, $signed(res(0, i, j)));
        end
      end
    clear_tiles(); fill_tile(1, 2, 3);  tick();
    clear_tiles(); fill_tile(2, -1, 5); tick();
    clear_tiles(); fill_tile(3, 4, 4);  tick();
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        n_vec++;
        if (res(3, i, j) !== 32'd131140) begin
          n_err++;
          $display("FAIL chain_r3[%0d][%0d]: got %0d want 131140", i, j, $signed(res(3, i, j)));
        end
      end
    clear_tiles(); valid_in = 1'b0; tick();
  endtask

  task automatic test_elementwise();
    int av [3] = '{32'h0200, -1, 32767};
    int bv [3] = '{32'hFF00, 1, 32767};
    logic [1:0] mv [3] = '{2'b01, 2'b01, 2'b10};
    int want [3] = '{-512, -1, 65534};
    for (int t = 0; t < 3; t++) begin
      mode = mv[t]; valid_in = 1'b1;
      for (int s = 0; s < 4; s++) fill_tile(s, av[t], bv[t]);
      tick();
      for (int s = 0; s < 4; s++)
        for (int i = 0; i < 4; i++)
          for (int j = 0; j < 4; j++) begin
            n_vec++;
            if ($signed(res(s, i, j)) !== want[t]) begin
              n_err++;
              $display("FAIL elem%0d_r%0d[%0d][%0d]: got %0d want %0d",
                       t, s, i, j, $signed(res(s, i, j)), want[t]);
            end
          end
    end
    valid_in = 1'b0; tick();
  endtask

  task automatic test_handshake();
    bit vin  [10] = '{1, 1, 1, 1, 1, 0, 1, 1, 0, 0};
    bit dexp [10] = '{0, 0, 0, 0, 0, 1, 0, 0, 1, 0};
    int pulses = 0;
    mode = 2'b00;
    for (int c = 0; c < 10; c++) begin
      valid_in = vin[c];
      randomize_tiles(-200, 200);
      tick();
      if (done_tile === 1'b1) pulses++;
      n_vec++;
      if (valid_out !== vin[c] || done_tile !== dexp[c]) begin
        n_err++;
        $display("FAIL hs_flags c%0d: got vo=%b done=%b want vo=%b done=%b",
                 c, valid_out, done_tile, vin[c], dexp[c]);
      end
      for (int s = 0; s < 4; s++)
        for (int i = 0; i < 4; i++)
          for (int j = 0; j < 4; j++) begin
            n_vec++;
            if ($signed(res(s, i, j)) !== m_r[s][i][j]) begin
              n_err++;
              $display("FAIL hs_r%0d[%0d][%0d] c%0d: got %0d want %0d",
                       s, i, j, c, $signed(res(s, i, j)), m_r[s][i][j]);
            end
          end
    end
    n_vec++;
    if (pulses != 2) begin
      n_err++;
      $display("FAIL hs_pulse_count: got %0d want 2", pulses);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 40; c++) begin
      mode     = 2'($urandom_range(3));
      valid_in = ($urandom_range(3) != 0);
      randomize_tiles(-32768, 32767);
      tick();
      n_vec++;
      if (valid_out !== m_vo || done_tile !== m_done) begin
        n_err++;
        $display("FAIL rnd_flags c%0d: got vo=%b done=%b want vo=%b done=%b",
                 c, valid_out, done_tile, m_vo, m_done);
      end
      for (int s = 0; s < 4; s++)
        for (int i = 0; i < 4; i++)
          for (int j = 0; j < 4; j++) begin
            n_vec++;
            if ($signed(res(s, i, j)) !== m_r[s][i][j]) begin
              n_err++;
              $display("FAIL rnd_r%0d[%0d][%0d] c%0d: got %0d want %0d",
                       s, i, j, c, $signed(res(s, i, j)), m_r[s][i][j]);
            end
          end
    end
    valid_in = 1'b0; tick();
  endtask

  task automatic test_reset_midburst();
    mode = 2'b00; valid_in = 1'b1;
    for (int c = 0; c < 3; c++) begin
      randomize_tiles(-1000, 1000);
      tick();
    end
    rst = 1'b1; randomize_tiles(-1000, 1000); tick();
    for (int s = 0; s < 4; s++)
      for (int i = 0; i < 4; i++)
        for (int j = 0; j < 4; j++) begin
          n_vec++;
          if (res(s, i, j) !== 32'd0) begin
            n_err++;
            $display("FAIL midrst_r%0d[%0d][%0d]: got %0d want 0", s, i, j, $signed(res(s, i, j)));
          end
        end
    n_vec++;
    if (valid_out !== 1'b0 || done_tile !== 1'b0) begin
      n_err++;
      $display("FAIL midrst_flags: got vo=%b done=%b want 0 0", valid_out, done_tile);
    end
    rst = 1'b0; valid_in = 1'b0; tick();
    n_vec++;
    if (done_tile !== 1'b0) begin
      n_err++;
      $display("FAIL midrst_nodone: got done=%b want 0", done_tile);
    end
  endtask

  task automatic test_matvec();
    int am [40][256];
    int bv [256];
    int row_acc [40];
    int want, kb, k;
    for (int k2 = 0; k2 < 256; k2++) begin
      bv[k2] = $urandom_range(127) - 64;
      for (int r = 0; r < 40; r++) am[r][k2] = $urandom_range(127) - 64;
    end
    foreach (row_acc[r]) row_acc[r] = 0;
    rst = 1'b1; valid_in = 1'b0; tick();
    rst = 1'b0; mode = 2'b00; valid_in = 1'b1;
    for (int blk = 0; blk < 10; blk++) begin
      for (int t = 0; t < 19; t++) begin
        for (int s = 0; s < 4; s++) begin
          kb = 16 * t - 12 * s;
          for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) begin
              k = kb + j;
              a_t[s][i][j] = (k >= 0 && k < 256) ? 16'(am[blk*4+i][k]) : 16'd0;
              b_t[s][i][j] = (k >= 0 && k < 256) ? 16'(bv[k]) : 16'd0;
            end
        end
        tick();
        for (int i = 0; i < 4; i++)
          for (int j = 0; j < 4; j++) row_acc[blk*4+i] += int'($signed(res(3, i, j)));
      end
    end
    valid_in = 1'b0; clear_tiles(); tick();
    for (int r = 0; r < 40; r++) begin
      want = 0;
      for (int k2 = 0; k2 < 256; k2++) want += am[r][k2] * bv[k2];
      want *= 4;
      n_vec++;
      if (row_acc[r] !== want) begin
        n_err++;
        $display("FAIL matvec_row%0d: got %0d want %0d", r, row_acc[r], want);
      end
    end
  endtask

  initial begin
    rst = 1'b1; valid_in = 1'b0; mode = 2'b00;
    clear_tiles();
    foreach (m_r[s, i, j]) m_r[s][i][j] = 0;
    m_vo = 0; m_done = 0;
    test_reset();
    test_mac_chain();
    test_elementwise();
    test_handshake();
    test_random();
    test_reset_midburst();
    test_matvec();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
